// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port unified memory arbiter between the fetch (IF) and
// memory-stage (DM) ports of the pipelined core. DM has priority in IDLE;
// reads occupy the memory for LAT+1 cycles, and writes complete at the grant edge.
// Optional feature macro: ARB_FAIR_EN. When it is defined, a starvation counter
// promotes a waiting fetch after STARVE_MAX consecutive DM grants.
module mem_arbiter #(
  parameter int MEM_A_W    = 10,
  parameter int DATA_W     = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  // fetch port
  input  logic               if_req_i,
  input  logic [MEM_A_W-1:0] if_addr_i,
  input  logic               if_kill_i,
  output logic               if_gnt_o,
  output logic               if_rvalid_o,
  output logic [DATA_W-1:0]  if_rdata_o,
  output logic               if_stall_o,
  // data port
  input  logic               dm_req_i,
  input  logic               dm_we_i,
  input  logic [MEM_A_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0]  dm_wdata_i,
  output logic               dm_gnt_o,
  output logic               dm_rvalid_o,
  output logic [DATA_W-1:0]  dm_rdata_o,
  output logic               dm_stall_o,
  // memory macro side
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [MEM_A_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  input  logic [DATA_W-1:0]  mem_rdata_i
);

  // Counter only needs to hold LAT-1.
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_drop;
  logic             w_drop_next;

  logic w_idle;
  logic w_if_ok;
  logic w_force_if;
  logic w_if_gnt;
  logic w_dm_gnt;
  logic w_done;
  logic w_if_rvalid;
  logic w_dm_rvalid;

  // Reset gates every grant/valid combinationally so outputs drop immediately
  // when reset is asserted, without waiting for a clock edge.
  assign w_idle  = (r_state == IDLE) & ~reset;
  assign w_if_ok = if_req_i & ~if_kill_i;
  assign w_done  = (r_cnt == '0);

`ifdef ARB_FAIR_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  logic [SC_W-1:0] r_starve;

  // Count DM grants taken while a fetch waits; saturate at STARVE_MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_if_gnt || !if_req_i) begin
      r_starve <= '0;
    end else if (w_dm_gnt && (r_starve != SC_W'(STARVE_MAX))) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign w_force_if = (r_starve == SC_W'(STARVE_MAX)) & w_if_ok;
`else
  assign w_force_if = 1'b0;
`endif

  // DM wins in IDLE unless a starved fetch is being promoted.
  assign w_dm_gnt = w_idle & dm_req_i & ~w_force_if;
  assign w_if_gnt = w_idle & w_if_ok & ~w_dm_gnt;

  // A kill in the completion cycle suppresses the fetch data as well.
  assign w_if_rvalid = ~reset & (r_state == BUSY_IF) & w_done & ~r_drop & ~if_kill_i;
  assign w_dm_rvalid = ~reset & (r_state == BUSY_DM) & w_done;

  // State, latency counter and drop flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_drop  <= w_drop_next;
    end
  end

  // Next-state logic: reads park in BUSY_x for LAT cycles; writes stay in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_drop_next  = r_drop;
    unique case (r_state)
      IDLE: begin
        w_drop_next = 1'b0;
        if (w_dm_gnt && !dm_we_i) begin
          w_state_next = BUSY_DM;
          w_cnt_next   = CNT_W'(LAT - 1);
        end else if (w_if_gnt) begin
          w_state_next = BUSY_IF;
          w_cnt_next   = CNT_W'(LAT - 1);
        end
      end
      BUSY_IF: begin
        if (if_kill_i) begin
          w_drop_next = 1'b1;
        end
        if (w_done) begin
          w_state_next = IDLE;
          w_drop_next  = 1'b0;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      BUSY_DM: begin
        if (w_done) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
        w_drop_next  = 1'b0;
      end
    endcase
  end

  // Memory strobe and port outputs; everything idles at zero.
  always_comb begin
    mem_req_o   = w_dm_gnt | w_if_gnt;
    mem_we_o    = w_dm_gnt & dm_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_dm_gnt) begin
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
    end else if (w_if_gnt) begin
      mem_addr_o = if_addr_i;
    end
    if_gnt_o    = w_if_gnt;
    dm_gnt_o    = w_dm_gnt;
    if_rvalid_o = w_if_rvalid;
    dm_rvalid_o = w_dm_rvalid;
    if_rdata_o  = w_if_rvalid ? mem_rdata_i : '0;
    dm_rdata_o  = w_dm_rvalid ? mem_rdata_i : '0;
    if_stall_o  = if_req_i & ~w_if_rvalid;
    dm_stall_o  = dm_req_i & ~(w_dm_gnt & dm_we_i) & ~w_dm_rvalid;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level reference model
// (busy-until time, scheduled completion, shadow memory) predicts every output.
module tb_mem_arbiter;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic if_req_i, if_kill_i, if_gnt_o, if_rvalid_o, if_stall_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o, dm_stall_o;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i, dm_rdata_o;
  logic mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  mem_arbiter #(.MEM_A_W(AW), .DATA_W(DW), .LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
    .dm_rdata_o(dm_rdata_o), .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Memory macro model: answers reads exactly LAT cycles after acceptance.
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  int            rd_due = -1;
  logic [DW-1:0] rd_val;

  // Reference model state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            next_free;   // first cycle a new grant may be issued
  int            pend_port;   // 0 none, 1 IF read, 2 DM read
  int            pend_cyc;    // cycle in which that read returns
  bit            pend_drop;
  logic [DW-1:0] pend_data;
  int            starve;
  bit            if_wait, dm_wait;

  initial begin
    bit free, force_if, e_dg, e_ig, e_ir, e_dr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    for (int i = 0; i < (1 << AW); i++) begin
      mem_arr[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1;
    if_req_i = 1'b1; if_addr_i = 10'h010; if_kill_i = 1'b0;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 10'h004; dm_wdata_i = '0;
    mem_rdata_i = 32'hDEADBEEF;
    next_free = 0; pend_port = 0; pend_cyc = -1; pend_drop = 1'b0;
    pend_data = '0; starve = 0; if_wait = 1'b0; dm_wait = 1'b0;

    // Under reset with both requests high: everything quiet, stalls pass through.
    @(negedge clk);
    chk("rst_if_gnt", if_gnt_o, 0);
    chk("rst_dm_gnt", dm_gnt_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_if_rvalid", if_rvalid_o, 0);
    chk("rst_dm_rdata", dm_rdata_o, 0);
    chk("rst_if_stall", if_stall_o, 1);
    chk("rst_dm_stall", dm_stall_o, 1);
    if_req_i = 1'b0; dm_req_i = 1'b0;

    for (int k = 0; k < 900; k++) begin
      @(posedge clk);
      #1;
      reset = (k > 0) && ($urandom_range(0, 79) == 0);
      mem_rdata_i = (rd_due == k) ? rd_val : $urandom();
      if (!if_wait) begin
        if_req_i  = ($urandom_range(0, 99) < 55);
        if_addr_i = AW'($urandom_range(0, 15));
      end
      if (!dm_wait) begin
        // A window of continuous DM traffic exercises starvation handling.
        dm_req_i   = (k >= 400 && k < 520) ? 1'b1 : ($urandom_range(0, 99) < 45);
        dm_we_i    = $urandom_range(0, 1) == 1;
        dm_addr_i  = AW'($urandom_range(0, 15));
        dm_wdata_i = $urandom();
      end
      if_kill_i = ($urandom_range(0, 99) < 8);
      @(negedge clk);

      if (reset) begin
        chk("r_if_gnt", if_gnt_o, 0);
        chk("r_dm_gnt", dm_gnt_o, 0);
        chk("r_if_rvalid", if_rvalid_o, 0);
        chk("r_dm_rvalid", dm_rvalid_o, 0);
        chk("r_mem_req", mem_req_o, 0);
        chk("r_if_stall", if_stall_o, if_req_i);
        chk("r_dm_stall", dm_stall_o, dm_req_i);
        $display("cyc %0d reset asserted", k);
        pend_port = 0; next_free = k + 1; starve = 0; pend_drop = 1'b0;
        if_wait = if_req_i; dm_wait = dm_req_i;
      end else begin
        free     = (k >= next_free);
        force_if = FAIR && (starve >= SMAX) && if_req_i && !if_kill_i;
        e_dg     = free && dm_req_i && !force_if;
        e_ig     = free && if_req_i && !if_kill_i && !e_dg;
        if (pend_port == 1 && if_kill_i) pend_drop = 1'b1;
        e_ir = (pend_port == 1) && (k == pend_cyc) && !pend_drop;
        e_dr = (pend_port == 2) && (k == pend_cyc);
        e_addr  = e_dg ? dm_addr_i : (e_ig ? if_addr_i : '0);
        e_wdata = e_dg ? dm_wdata_i : '0;

        chk("if_gnt", if_gnt_o, e_ig);
        chk("dm_gnt", dm_gnt_o, e_dg);
        chk("if_rvalid", if_rvalid_o, e_ir);
        chk("dm_rvalid", dm_rvalid_o, e_dr);
        chk("if_rdata", if_rdata_o, e_ir ? pend_data : '0);
        chk("dm_rdata", dm_rdata_o, e_dr ? pend_data : '0);
        chk("mem_req", mem_req_o, e_dg || e_ig);
        chk("mem_we", mem_we_o, e_dg && dm_we_i);
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_wdata", mem_wdata_o, e_wdata);
        chk("if_stall", if_stall_o, if_req_i && !e_ir);
        chk("dm_stall", dm_stall_o, dm_req_i && !(e_dg && dm_we_i) && !e_dr);

        if (e_ir) $display("cyc %0d IF rvalid data 0x%08h", k, if_rdata_o);
        if (e_dr) $display("cyc %0d DM rvalid data 0x%08h", k, dm_rdata_o);
        if (k == pend_cyc) pend_port = 0;

        if (e_dg && dm_we_i) begin
          ref_mem[dm_addr_i] = dm_wdata_i;
          next_free = k + 1;
          $display("cyc %0d DM write addr 0x%03h data 0x%08h", k, dm_addr_i, dm_wdata_i);
        end else if (e_dg) begin
          pend_port = 2; pend_cyc = k + LAT; pend_data = ref_mem[dm_addr_i];
          next_free = k + LAT + 1;
          $display("cyc %0d DM read addr 0x%03h", k, dm_addr_i);
        end else if (e_ig) begin
          pend_port = 1; pend_cyc = k + LAT; pend_data = ref_mem[if_addr_i];
          pend_drop = 1'b0; next_free = k + LAT + 1;
          $display("cyc %0d IF read addr 0x%03h", k, if_addr_i);
        end

        if (e_ig || !if_req_i) starve = 0;
        else if (e_dg && starve < SMAX) starve++;

        if_wait = if_req_i && !e_ig;
        dm_wait = dm_req_i && !e_dg;
      end

      // Memory macro reacts to whatever the arbiter actually drove.
      if (mem_req_o) begin
        if (mem_we_o) mem_arr[mem_addr_o] = mem_wdata_o;
        else begin
          rd_due = k + LAT;
          rd_val = mem_arr[mem_addr_o];
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port unified memory arbiter for the pipelined RISC-V core. It shares one fixed-latency memory between the fetch stage's instruction port (IF) and the memory stage's data port (DM). It sequences each access through a small state machine and cancels in-flight fetches on branch redirect. It sits between the fetch/memory stages and the memory macro and generates per-port stall signals for the pipeline.

## Interface
- MEM_A_W, 10, memory word-address width
- DATA_W, 32, data width
- LAT, 2, read latency in cycles (≥1); mem_rdata_i valid exactly LAT cycles after the accept edge
- STARVE_MAX, 4, consecutive DM grants tolerated while IF waits (ARB_FAIR_EN only)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req_i  in  1  fetch read request
- if_addr_i  in  MEM_A_W  fetch address
- if_kill_i  in  1  branch redirect; cancel any pending or in-flight fetch
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  DATA_W  fetch data
- if_stall_o  out  1  if_req_i & ~if_rvalid_o
- dm_req_i  in  1  data request
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  MEM_A_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_gnt_o  out  1  data request accepted
- dm_rvalid_o  out  1  data read valid
- dm_rdata_o  out  DATA_W  data read value
- dm_stall_o  out  1  dm_req_i & ~(dm_gnt_o & dm_we_i) & ~dm_rvalid_o
- mem_req_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  MEM_A_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data

## Operation
- States: IDLE, BUSY_IF, BUSY_DM. Grants are issued only in IDLE, combinationally from the request inputs.
- Priority in IDLE: DM over IF (the older instruction wins). A DM grant forces IF to wait even if both requests arrive in the same cycle.
- Grant cycle: gnt_o=1, mem_req_o=1, and mem_addr_o/mem_we_o/mem_wdata_o are driven from the granted port. At the edge, the latency counter loads LAT-1.
- DM write: completes at the grant edge. State stays IDLE and no rvalid is produced.
- Reads: the state moves to BUSY_x and the counter decrements each cycle. In the cycle the counter is 0:
  - x_rvalid_o=1 and x_rdata_o=mem_rdata_i (passthrough).
  - Next state is IDLE.
  - Read throughput is one access per LAT+1 cycles.
- When idle, mem_req_o=0 and mem_addr_o/mem_wdata_o=0.
- if_kill_i in IDLE: IF is not granted that cycle; DM arbitration is unaffected.
- if_kill_i in BUSY_IF (any cycle, including the completion cycle):
  - Sets the drop flag.
  - The memory cycle completes, but if_rvalid_o is suppressed.
  - The drop flag clears on return to IDLE.
- if_rdata_o and dm_rdata_o are 0 when their rvalid is low.
- Requesters hold req/addr/wdata stable until gnt. After gnt they may change freely.

## Timing
- Reset (async): state=IDLE, counter=0, drop flag=0, starvation counter=0. All outputs 0, except passthrough stall terms, which follow the inputs. An in-flight read is abandoned with no rvalid.
- Read latency: gnt in cycle 0, rvalid in cycle LAT, next grant possible in cycle LAT+1.
- Write latency: gnt in cycle 0, next grant possible in cycle 1.
- A request arriving in the rvalid cycle is not granted until the following cycle.

## Configuration
- ARB_FAIR_EN defined:
  - A starvation counter increments on each DM grant while if_req_i is high and IF is not granted.
  - When the counter reaches STARVE_MAX, the next IDLE cycle with if_req_i and no if_kill_i grants IF over DM.
  - The counter clears on any IF grant or when if_req_i is low.
- ARB_FAIR_EN undefined: strict DM priority, and no starvation counter is instantiated.

## Test plan
- LAT=2, IF read addr 0x010 alone; memory returns 0xDEADBEEF → if_gnt_o in cycle 0, if_rvalid_o=1 with 0xDEADBEEF in cycle 2 only, if_stall_o high in cycles 0–1.
- IF and DM reads issued in the same cycle → dm_gnt_o in cycle 0, dm_rvalid_o in cycle 2, if_gnt_o in cycle 3, if_rvalid_o in cycle 5.
- Back-to-back DM writes 0x5→0x004 and 0x6→0x008 → gnt in cycles 0 and 1, mem_we_o=1 both cycles, no rvalid.
- if_kill_i pulsed in cycle 1 of a fetch → no if_rvalid_o, state IDLE by cycle 3, and a new IF request in cycle 3 is granted.
- reset asserted in cycle 1 of a DM read → all outputs 0 immediately, no dm_rvalid_o, and a grant is available in the first cycle after reset deasserts.
- ARB_FAIR_EN, STARVE_MAX=4, DM requesting continuously with IF pending → four DM grants, then an IF grant, then DM again.
